// File: rtl/x_s3e_spm_mp_pkg.sv
// Shared constants and types for the S3E dual-port scratchpad.
// Holds default widths, byte-lane count, enable/reset levels and clear FSM encoding.
package x_s3e_spm_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 11;
  localparam int LANES_DEF  = DATA_W_DEF / 8;

  localparam logic ENABLE     = 1'b1;
  localparam logic DISABLE    = 1'b0;
  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_t;

endpackage

// File: rtl/x_s3e_spm_merge.sv
// Per-byte merge of both ports' writes onto a stored word at one address.
// Combinational; port A wins byte conflicts, unwritten bytes keep the stored value.
module x_s3e_spm_merge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   stored,
  input  logic                a_wr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic                b_wr,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   word
);

  localparam int NB = DATA_W / 8;

  logic a_hit, b_hit;

  assign a_hit = a_wr && (a_addr == addr);
  assign b_hit = b_wr && (b_addr == addr);

  always_comb begin
    word = stored;
    for (int i = 0; i < NB; i++) begin
      if (a_hit && a_be[i])
        word[8*i +: 8] = a_wdata[8*i +: 8];
      else if (b_hit && b_be[i])
        word[8*i +: 8] = b_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/x_s3e_spm_mp.sv
// True-dual-port byte-enable scratchpad with cross-port forwarding, read latency 1 (+1 with OUT_REG).
// Define SPM_CLEAR_EN to compile in the post-reset clear sequencer that zeroes the array.
module x_s3e_spm_mp
  import x_s3e_spm_mp_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OUT_REG = 0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_en,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              a_wr, b_wr;
  logic [1:0]        rd;
  logic [1:0][DATA_W-1:0] word;
  logic              clr_wr;
  logic [ADDR_W-1:0] clr_addr;

  assign a_wr  = a_en && ready && a_we;
  assign b_wr  = b_en && ready && b_we;
  assign rd[0] = a_en && ready && !a_we;
  assign rd[1] = b_en && ready && !b_we;

  // Each merged word is both the forwarded read value and the write-back value for its address.
  x_s3e_spm_merge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_merge_a (
    .addr(a_addr), .stored(mem[a_addr]),
    .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .word(word[0])
  );

  x_s3e_spm_merge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_merge_b (
    .addr(b_addr), .stored(mem[b_addr]),
    .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .word(word[1])
  );

  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_addr] <= '0;
    end else begin
      if (a_wr) mem[a_addr] <= word[0];
      if (b_wr) mem[b_addr] <= word[1];
    end
  end

`ifdef SPM_CLEAR_EN
  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset == RST_ACTIVE) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_CLEAR) begin
      cnt_nxt = cnt + 1'b1;
      if (&cnt) state_nxt = ST_RUN;
    end
  end

  assign ready    = (state == ST_RUN);
  assign clr_wr   = (reset != RST_ACTIVE) && (state == ST_CLEAR);
  assign clr_addr = cnt;
`else
  assign ready    = ENABLE;
  assign clr_wr   = DISABLE;
  assign clr_addr = '0;
`endif

  // Read data only updates on a valid read so rdata holds between strobes.
  logic [1:0]             s1_vld, o_vld;
  logic [1:0][DATA_W-1:0] s1_dat, o_dat;

  always_ff @(posedge clk) begin
    if (reset == RST_ACTIVE) begin
      s1_vld <= '0;
      s1_dat <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        s1_vld[p] <= rd[p];
        if (rd[p]) s1_dat[p] <= word[p];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [1:0]             s2_vld;
      logic [1:0][DATA_W-1:0] s2_dat;

      always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
          s2_vld <= '0;
          s2_dat <= '0;
        end else begin
          for (int p = 0; p < 2; p++) begin
            s2_vld[p] <= s1_vld[p];
            if (s1_vld[p]) s2_dat[p] <= s1_dat[p];
          end
        end
      end

      assign o_vld = s2_vld;
      assign o_dat = s2_dat;
    end else begin : g_noreg
      assign o_vld = s1_vld;
      assign o_dat = s1_dat;
    end
  endgenerate

  assign a_rvalid = o_vld[0];
  assign a_rdata  = o_dat[0];
  assign b_rvalid = o_vld[1];
  assign b_rdata  = o_dat[1];

endmodule
